cpu_controller: RTL and testbench
=================================

// Module: cpu_controller
// PURPOSE
// - Fetch/decode/sequence FSM for the 16-bit RISC datapath: owns PC, instruction register (IR) and data-address register (DA).
// - Drives every datapath strobe and select, plus the memory command and address.
// - Sits between the instruction/data memory and the datapath; one controller per datapath.
// PARAMETERS
// - PC_WIDTH  9     width of PC, DA and mem_addr
// - RESET_PC  9'd0  PC value loaded in state RST
// PORTS
// - clk        in   1   rising-edge clock
// - reset      in   1   synchronous, active-high
// - mem_rdata  in   16  memory read data; only loaded into IR
// - mem_cmd    out  2   00 NONE, 01 READ, 10 WRITE; write data is the datapath C
// - mem_addr   out  9   PC in fetch states, DA in load/store states, else PC
// - PC_out     out  9   current PC, drives the datapath PC_in
// - sximm5     out  16  {{11{IR[4]}},IR[4:0]}
// - sximm8     out  16  {{8{IR[7]}},IR[7:0]}
// - readnum, writenum  out  3  register-file indices: Rn=IR[10:8], Rd=IR[7:5], Rm=IR[2:0]
// - vsel       out  4   one-hot: 1000 mdata, 0100 sximm8, 0010 PC, 0001 C
// - loada, loadb, loadc, loads, write  out  1  datapath strobes
// - asel, bsel out  1   1 selects 0 for A, 1 selects sximm5 for B
// - shift      out  2   IR[4:3] in EXEC, else 00
// - ALUop      out  2   00 ADD, 01 SUB, 10 AND, 11 NOT-B
// - halted     out  1   high in HALT
// BEHAVIOUR
// - Moore machine: all outputs decode from the state register, IR and DA only; no input-to-output combinational path.
// - Reset: state RST, IR=0, DA=0. In RST: PC<=RESET_PC, all strobes 0, mem_cmd NONE, halted 0. Reset wins over everything; reset during any state (mid-STR, HALT) aborts it next edge.
// - Strobes and mem_cmd default to 0/NONE in every state not listed below.
// - Fetch sequence:
//   - RST -> IF1.
//   - IF1: mem_addr=PC, mem_cmd=READ -> IF2.
//   - IF2: mem_addr=PC, mem_cmd=READ, IR<=mem_rdata -> UPD.
//   - UPD: PC<=PC+1, mod 2^PC_WIDTH (511 -> 0) -> DEC.
// - DEC dispatch on IR[15:13],IR[12:11]:
//   - 110/10 MOV-imm -> WIMM.
//   - 110/00 MOV-reg -> GETB.
//   - 101/xx ALU -> GETA.
//   - 011/00 LDR, 100/00 STR -> GETA.
//   - 111 HALT -> HALT.
//   - Any other code is a NOP -> IF1.
// - WIMM: writenum=Rn, vsel=sximm8, write=1 -> IF1.
// - GETA: readnum=Rn, loada=1 -> GETB for ALU, ADDR for LDR/STR.
// - GETB: readnum=Rm, loadb=1 -> EXEC.
// - EXEC: asel=(MOV-reg), bsel=0, shift=IR[4:3].
//   - ALUop=IR[12:11]; MOV-reg uses 00.
//   - CMP (101/01): loads=1, loadc=0 -> IF1.
//   - Others: loadc=1 -> WRD.
// - WRD: writenum=Rd, vsel=C, write=1 -> IF1.
// - ADDR: asel=0, bsel=1, ALUop=ADD, loadc=1 -> LDA.
// - LDA: DA<=C[8:0] -> RD1 for LDR, SGET for STR.
// - LDR path:
//   - RD1: mem_addr=DA, mem_cmd=READ -> RD2.
//   - RD2: mem_addr=DA, mem_cmd=READ, writenum=Rd, vsel=mdata, write=1 -> IF1.
// - STR path:
//   - SGET: readnum=Rd, loadb=1 -> SMOV.
//   - SMOV: asel=1, bsel=0, ALUop=ADD, loadc=1 -> SWR.
//   - SWR: mem_addr=DA, mem_cmd=WRITE for exactly 1 cycle -> IF1.
// - HALT: halted=1, mem_cmd NONE, PC frozen, stays until reset.
// - Cycle counts, IF1 to next IF1:
//   - MOV-imm 5.
//   - CMP 7; MOV-reg 7.
//   - ADD/AND/MVN 8.
//   - LDR 9.
//   - STR 10.
// STRUCTURE
// - cpu_pkg: state enum, opcode/op constants, VSEL_* one-hot, MEM_CMD_*, ALU_* codes.
// - Sub-module instr_decoder: IR -> fields, sximm5/sximm8, nsel-driven readnum/writenum mux.
// - Top holds the FSM, PC, IR and DA registers.
// TESTING
// - reset=1 for 2 cycles -> PC_out=0, mem_cmd=00, all strobes 0; release -> next cycle IF1, mem_addr=0, mem_cmd=01.
// - Fetch 0xD0FD (MOV R0,#-3) -> write=1, writenum=0, vsel=0100, sximm8=16'hFFFD, PC_out=1, 5 cycles total.
// - Fetch 0xA148 (ADD R2,R1,R0,LSL#1):
//   - readnum 1 with loada, then readnum 0 with loadb.
//   - EXEC: shift=01, ALUop=00, loadc.
//   - writenum=2, vsel=0001 write.
// - Fetch 0xA900 (CMP R1,R0) -> loads=1 for 1 cycle, ALUop=01, write never high.
// - Fetch 0x617F (LDR R3,[R1,#-1]) with R1=5 -> bsel=1, sximm5=16'hFFFF; mem_addr=4, READ for 2 cycles; writenum=3, vsel=1000.
// - Fetch 0x8162 (STR R3,[R1,#2]) with R1=5 -> mem_cmd=10 for 1 cycle, mem_addr=7.
//   - Assert reset during RD1 -> next cycle RST, mem_cmd=00.
//   - 0xE000 -> halted=1 indefinitely.
//   - PC=511 fetch -> PC wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Purpose : shared types and encodings for the 16-bit RISC controller (states, opcodes, selects).
// Latency : n/a (definitions only).
// Backpressure: n/a.
//
// Contents: state_t FSM encoding, opcode/op field constants, VSEL_* one-hot
// writeback selects, MEM_CMD_* memory commands, ALU_* operation codes,
// NSEL_* register-index selects and the sign-extension helpers.
package cpu_pkg;

    typedef enum logic [4:0] {
        S_RST,
        S_IF1,
        S_IF2,
        S_UPD,
        S_DEC,
        S_WIMM,
        S_GETA,
        S_GETB,
        S_EXEC,
        S_WRD,
        S_ADDR,
        S_LDA,
        S_RD1,
        S_RD2,
        S_SGET,
        S_SMOV,
        S_SWR,
        S_HALT
    } state_t;

    // IR[15:13]
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // IR[12:11]
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MEM     = 2'b00;

    // Writeback source select, one-hot
    localparam logic [3:0] VSEL_NONE   = 4'b0000;
    localparam logic [3:0] VSEL_MDATA  = 4'b1000;
    localparam logic [3:0] VSEL_SXIMM8 = 4'b0100;
    localparam logic [3:0] VSEL_PC     = 4'b0010;
    localparam logic [3:0] VSEL_C      = 4'b0001;

    localparam logic [1:0] MEM_CMD_NONE  = 2'b00;
    localparam logic [1:0] MEM_CMD_READ  = 2'b01;
    localparam logic [1:0] MEM_CMD_WRITE = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    // Register-index select, one-hot {Rn, Rd, Rm}
    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purpose : splits the instruction register into fields, immediates and the register index.
// Latency : purely combinational, zero cycles.
// Backpressure: none; follows IR and nsel every cycle.
//
// Ports: ir (instruction register), nsel (one-hot Rn/Rd/Rm select) in;
// opcode, op, shift_fld, sximm5, sximm8, regnum out.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [2:0]  nsel,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [1:0]  shift_fld,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output logic [2:0]  regnum
);

    assign opcode    = ir[15:13];
    assign op        = ir[12:11];
    assign shift_fld = ir[4:3];
    assign sximm5    = sext5(ir[4:0]);
    assign sximm8    = sext8(ir[7:0]);

    // Index for the register file; zero when no state needs a register.
    always_comb begin
        regnum = 3'b000;
        case (nsel)
            NSEL_RN: regnum = ir[10:8];
            NSEL_RD: regnum = ir[7:5];
            NSEL_RM: regnum = ir[2:0];
            default: regnum = 3'b000;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Purpose : fetch/decode/sequence FSM owning PC, IR and DA; drives all datapath strobes and memory commands.
// Latency : 4-10 cycles per instruction from IF1 to the next IF1, fixed per instruction class.
// Backpressure: none; memory is assumed to return read data during the second read cycle.
//
// Ports: clk, reset (sync, active-high), mem_rdata (loaded into IR only),
// datapath_c (datapath C result, low PC_WIDTH bits captured into DA);
// mem_cmd/mem_addr to memory; PC_out, sximm5, sximm8, readnum, writenum,
// vsel, loada/loadb/loadc/loads/write, asel, bsel, shift, ALUop to the
// datapath; halted status.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH = 9,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         mem_rdata,
    input  logic [15:0]         datapath_c,
    output logic [1:0]          mem_cmd,
    output logic [PC_WIDTH-1:0] mem_addr,
    output logic [PC_WIDTH-1:0] PC_out,
    output logic [15:0]         sximm5,
    output logic [15:0]         sximm8,
    output logic [2:0]          readnum,
    output logic [2:0]          writenum,
    output logic [3:0]          vsel,
    output logic                loada,
    output logic                loadb,
    output logic                loadc,
    output logic                loads,
    output logic                write,
    output logic                asel,
    output logic                bsel,
    output logic [1:0]          shift,
    output logic [1:0]          ALUop,
    output logic                halted
);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [PC_WIDTH-1:0] da_q, da_d;

    logic [2:0]  nsel;
    logic [2:0]  regnum;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [1:0]  shift_fld;
    logic        is_mov_reg;
    logic        is_cmp;
    logic        unused_c_hi;

    // Only the address-sized slice of C ever reaches DA.
    assign unused_c_hi = ^datapath_c[15:PC_WIDTH];

    instr_decoder u_dec (
        .ir        (ir_q),
        .nsel      (nsel),
        .opcode    (opcode),
        .op        (op),
        .shift_fld (shift_fld),
        .sximm5    (sximm5),
        .sximm8    (sximm8),
        .regnum    (regnum)
    );

    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign is_cmp     = (opcode == OPC_ALU) && (op == OP_CMP);

    // Next-state, PC, IR and DA update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        da_d    = da_q;
        case (state_q)
            S_RST: begin
                pc_d    = RESET_PC;
                state_d = S_IF1;
            end
            S_IF1: state_d = S_IF2;
            S_IF2: begin
                ir_d    = mem_rdata;
                state_d = S_UPD;
            end
            S_UPD: begin
                // Natural wrap at 2^PC_WIDTH.
                pc_d    = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
                state_d = S_DEC;
            end
            S_DEC: begin
                state_d = S_IF1;   // unknown encodings behave as NOP
                case (opcode)
                    OPC_MOV: begin
                        if (op == OP_MOV_IMM)      state_d = S_WIMM;
                        else if (op == OP_MOV_REG) state_d = S_GETB;
                    end
                    OPC_ALU:  state_d = S_GETA;
                    OPC_LDR,
                    OPC_STR: begin
                        if (op == OP_MEM) state_d = S_GETA;
                    end
                    OPC_HALT: state_d = S_HALT;
                    default:  state_d = S_IF1;
                endcase
            end
            S_WIMM: state_d = S_IF1;
            S_GETA: state_d = (opcode == OPC_ALU) ? S_GETB : S_ADDR;
            S_GETB: state_d = S_EXEC;
            S_EXEC: state_d = is_cmp ? S_IF1 : S_WRD;
            S_WRD:  state_d = S_IF1;
            S_ADDR: state_d = S_LDA;
            S_LDA: begin
                da_d    = datapath_c[PC_WIDTH-1:0];
                state_d = (opcode == OPC_LDR) ? S_RD1 : S_SGET;
            end
            S_RD1:  state_d = S_RD2;
            S_RD2:  state_d = S_IF1;
            S_SGET: state_d = S_SMOV;
            S_SMOV: state_d = S_SWR;
            S_SWR:  state_d = S_IF1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RST;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            da_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            da_q    <= da_d;
        end
    end

    assign PC_out   = pc_q;
    assign readnum  = regnum;
    assign writenum = regnum;

    // Moore output decode: depends on state_q, IR and DA only.
    always_comb begin
        nsel     = NSEL_NONE;
        vsel     = VSEL_NONE;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        write    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = ALU_ADD;
        mem_cmd  = MEM_CMD_NONE;
        mem_addr = pc_q;
        halted   = 1'b0;
        case (state_q)
            S_IF1,
            S_IF2: mem_cmd = MEM_CMD_READ;
            S_WIMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_SXIMM8;
                write = 1'b1;
            end
            S_GETA: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            S_GETB: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            S_EXEC: begin
                // MOV-reg passes B through an ADD with A forced to zero.
                asel  = is_mov_reg;
                shift = shift_fld;
                ALUop = is_mov_reg ? ALU_ADD : op;
                if (is_cmp) loads = 1'b1;
                else        loadc = 1'b1;
            end
            S_WRD: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            S_ADDR: begin
                bsel  = 1'b1;
                loadc = 1'b1;
            end
            S_RD1: begin
                mem_cmd  = MEM_CMD_READ;
                mem_addr = da_q;
            end
            S_RD2: begin
                mem_cmd  = MEM_CMD_READ;
                mem_addr = da_q;
                nsel     = NSEL_RD;
                vsel     = VSEL_MDATA;
                write    = 1'b1;
            end
            S_SGET: begin
                nsel  = NSEL_RD;
                loadb = 1'b1;
            end
            S_SMOV: begin
                // Rd flows to C via 0 + B so C carries the store data.
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_SWR: begin
                mem_cmd  = MEM_CMD_WRITE;
                mem_addr = da_q;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Purpose : self-checking bench for cpu_controller using a program table and an expectation queue.
// Latency : n/a.
// Backpressure: n/a.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_rdata;
    logic [15:0] datapath_c;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [8:0]  PC_out;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [3:0]  vsel;
    logic        loada, loadb, loadc, loads, write;
    logic        asel, bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic        halted;

    logic [15:0] mem [0:511];
    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    cpu_controller dut (
        .clk        (clk),
        .reset      (reset),
        .mem_rdata  (mem_rdata),
        .datapath_c (datapath_c),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .PC_out     (PC_out),
        .sximm5     (sximm5),
        .sximm8     (sximm8),
        .readnum    (readnum),
        .writenum   (writenum),
        .vsel       (vsel),
        .loada      (loada),
        .loadb      (loadb),
        .loadc      (loadc),
        .loads      (loads),
        .write      (write),
        .asel       (asel),
        .bsel       (bsel),
        .shift      (shift),
        .ALUop      (ALUop),
        .halted     (halted)
    );

    // One record per instruction: stimulus plus what the window from its
    // DEC cycle up to the next instruction's UPD cycle must show.
    typedef struct {
        logic [15:0] instr;
        logic [15:0] c_val;
        int          cycles;
        int          n_write;
        logic [2:0]  wr_num;
        logic [3:0]  wr_vsel;
        int          n_loada;
        logic [2:0]  ra_num;
        int          n_loadb;
        logic [2:0]  rb_num;
        int          n_loadc;
        int          n_loads;
        logic [1:0]  alu;
        logic        asel;
        logic        bsel;
        logic [1:0]  shift;
        int          n_read;
        logic [8:0]  rd_addr;
        int          n_mwr;
        logic [8:0]  wr_addr;
        logic [15:0] sx5;
        logic [15:0] sx8;
        logic [8:0]  pc;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vec [NVEC];
    vec_t exp_q [$];
    vec_t obs;

    int n_pass  = 0;
    int n_total = 0;
    int idx     = 0;
    bit active  = 0;
    bit done    = 0;
    bit first_alu;
    bit first_rd;
    logic [8:0] prev_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic score();
        vec_t e;
        int   i;
        i = idx - 1;
        e = exp_q.pop_front();
        check($sformatf("v%0d_cycles", i),  obs.cycles,  e.cycles);
        check($sformatf("v%0d_n_write", i), obs.n_write, e.n_write);
        check($sformatf("v%0d_wr_num", i),  obs.wr_num,  e.wr_num);
        check($sformatf("v%0d_wr_vsel", i), obs.wr_vsel, e.wr_vsel);
        check($sformatf("v%0d_n_loada", i), obs.n_loada, e.n_loada);
        check($sformatf("v%0d_ra_num", i),  obs.ra_num,  e.ra_num);
        check($sformatf("v%0d_n_loadb", i), obs.n_loadb, e.n_loadb);
        check($sformatf("v%0d_rb_num", i),  obs.rb_num,  e.rb_num);
        check($sformatf("v%0d_n_loadc", i), obs.n_loadc, e.n_loadc);
        check($sformatf("v%0d_n_loads", i), obs.n_loads, e.n_loads);
        check($sformatf("v%0d_aluop", i),   obs.alu,     e.alu);
        check($sformatf("v%0d_asel", i),    obs.asel,    e.asel);
        check($sformatf("v%0d_bsel", i),    obs.bsel,    e.bsel);
        check($sformatf("v%0d_shift", i),   obs.shift,   e.shift);
        check($sformatf("v%0d_n_read", i),  obs.n_read,  e.n_read);
        check($sformatf("v%0d_rd_addr", i), obs.rd_addr, e.rd_addr);
        check($sformatf("v%0d_n_mwr", i),   obs.n_mwr,   e.n_mwr);
        check($sformatf("v%0d_wr_addr", i), obs.wr_addr, e.wr_addr);
        check($sformatf("v%0d_sximm5", i),  obs.sx5,     e.sx5);
        check($sformatf("v%0d_sximm8", i),  obs.sx8,     e.sx8);
        check($sformatf("v%0d_pc", i),      obs.pc,      e.pc);
    endtask

    // Called once per cycle at the falling edge. A PC change marks the DEC
    // cycle of a new instruction and closes the previous window.
    task automatic monitor();
        if (PC_out !== prev_pc) begin
            if (active) score();
            if (idx < NVEC) begin
                active     = 1;
                datapath_c = vec[idx].c_val;
                idx++;
                obs        = '{default: '0};
                first_alu  = 0;
                first_rd   = 0;
                obs.sx5    = sximm5;
                obs.sx8    = sximm8;
                obs.pc     = PC_out;
            end else begin
                active = 0;
                done   = 1;
            end
            prev_pc = PC_out;
        end
        if (active) begin
            obs.cycles++;
            if (write) begin obs.n_write++; obs.wr_num = writenum; obs.wr_vsel = vsel; end
            if (loada) begin obs.n_loada++; obs.ra_num = readnum; end
            if (loadb) begin obs.n_loadb++; obs.rb_num = readnum; end
            if (loadc) obs.n_loadc++;
            if (loads) obs.n_loads++;
            if ((loadc || loads) && !first_alu) begin
                first_alu = 1;
                obs.alu   = ALUop;
                obs.asel  = asel;
                obs.bsel  = bsel;
                obs.shift = shift;
            end
            if (mem_cmd == 2'b01) begin
                obs.n_read++;
                if (!first_rd) begin first_rd = 1; obs.rd_addr = mem_addr; end
            end
            if (mem_cmd == 2'b10) begin obs.n_mwr++; obs.wr_addr = mem_addr; end
        end
    endtask

    initial begin
        //          instr     c     cyc wr wrn  vsel     la ra    lb rb    lc ls alu   as bs sh     rd rda    mw wra    sx5       sx8       pc
        vec[0] = '{16'hD0FD, 16'd0, 5,  1, 3'd0, 4'b0100, 0, 3'd0, 0, 3'd0, 0, 0, 2'b00, 0, 0, 2'b00, 2, 9'd1, 0, 9'd0, 16'hFFFD, 16'hFFFD, 9'd1};
        vec[1] = '{16'hA148, 16'd0, 8,  1, 3'd2, 4'b0001, 1, 3'd1, 1, 3'd0, 1, 0, 2'b00, 0, 0, 2'b01, 2, 9'd2, 0, 9'd0, 16'h0008, 16'h0048, 9'd2};
        vec[2] = '{16'hA900, 16'd0, 7,  0, 3'd0, 4'b0000, 1, 3'd1, 1, 3'd0, 0, 1, 2'b01, 0, 0, 2'b00, 2, 9'd3, 0, 9'd0, 16'h0000, 16'h0000, 9'd3};
        vec[3] = '{16'h617F, 16'd4, 9,  1, 3'd3, 4'b1000, 1, 3'd1, 0, 3'd0, 1, 0, 2'b00, 0, 1, 2'b00, 4, 9'd4, 0, 9'd0, 16'hFFFF, 16'h007F, 9'd4};
        vec[4] = '{16'h8162, 16'd7, 10, 0, 3'd0, 4'b0000, 1, 3'd1, 1, 3'd3, 2, 0, 2'b00, 0, 1, 2'b00, 2, 9'd5, 1, 9'd7, 16'h0002, 16'h0062, 9'd5};
        vec[5] = '{16'hC04B, 16'd0, 7,  1, 3'd2, 4'b0001, 0, 3'd0, 1, 3'd3, 1, 0, 2'b00, 1, 0, 2'b01, 2, 9'd6, 0, 9'd0, 16'h000B, 16'h004B, 9'd6};
        vec[6] = '{16'h2000, 16'd0, 4,  0, 3'd0, 4'b0000, 0, 3'd0, 0, 3'd0, 0, 0, 2'b00, 0, 0, 2'b00, 2, 9'd7, 0, 9'd0, 16'h0000, 16'h0000, 9'd7};
        vec[7] = '{16'hB8E1, 16'd0, 8,  1, 3'd7, 4'b0001, 1, 3'd0, 1, 3'd1, 1, 0, 2'b11, 0, 0, 2'b00, 2, 9'd8, 0, 9'd0, 16'h0001, 16'hFFE1, 9'd8};

        reset      = 1'b1;
        datapath_c = '0;
        for (int a = 0; a < 512; a++) mem[a] = 16'hE000;
        for (int i = 0; i < NVEC; i++) begin
            mem[i] = vec[i].instr;
            exp_q.push_back(vec[i]);
        end
        mem[NVEC] = 16'hE000;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc", PC_out, 9'd0);
        check("rst_mem_cmd", mem_cmd, 2'b00);
        check("rst_strobes", {loada, loadb, loadc, loads, write, asel, bsel}, 7'd0);
        check("rst_halted", halted, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("if1_mem_cmd", mem_cmd, 2'b01);
        check("if1_mem_addr", mem_addr, 9'd0);

        // Program run through the expectation queue
        prev_pc = PC_out;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            monitor();
        end
        check("run_pending_expectations", exp_q.size(), 0);

        // HALT holds with PC frozen and no memory traffic
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("halt_flag_%0d", k), halted, 1'b1);
            check($sformatf("halt_pc_%0d", k), PC_out, 9'd9);
            check($sformatf("halt_mem_cmd_%0d", k), mem_cmd, 2'b00);
        end

        // Reset during RD1 of an LDR aborts it on the next edge
        reset = 1'b1;
        mem[0] = 16'h617F;
        datapath_c = 16'd4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("rd1_mem_cmd", mem_cmd, 2'b01);
        check("rd1_mem_addr", mem_addr, 9'd4);
        check("rd1_write", write, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_mem_cmd", mem_cmd, 2'b00);
        check("abort_write", write, 1'b0);
        check("abort_pc", PC_out, 9'd0);
        reset = 1'b0;
        @(negedge clk);
        check("restart_mem_cmd", mem_cmd, 2'b01);
        check("restart_mem_addr", mem_addr, 9'd0);

        // PC wraps from 511 to 0 across a run of NOPs
        reset = 1'b1;
        for (int a = 0; a < 512; a++) mem[a] = 16'h2000;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 2300 && PC_out != 9'd511; k++) @(negedge clk);
        check("wrap_reach_511", PC_out, 9'd511);
        begin
            bit saw_fetch = 0;
            for (int k = 0; k < 12 && PC_out == 9'd511; k++) begin
                @(negedge clk);
                if (mem_cmd == 2'b01 && mem_addr == 9'd511) saw_fetch = 1;
            end
            check("wrap_fetch_511", saw_fetch, 1'b1);
        end
        check("wrap_pc_zero", PC_out, 9'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
